// File: rtl/svreal_sched_pkg.sv
// Shared types and elaboration-time helpers for the svreal multiplier scheduler.
// The rescale helper turns the three fixed-point exponents into a shift direction and amount.
package svreal_sched_pkg;

  typedef struct packed {
    logic       right;
    logic [7:0] amt;
  } shift_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  // right=1: arithmetic right shift (coarser output LSB); right=0: left shift.
  function automatic shift_t rescale_shift(input int a_exp, input int b_exp, input int c_exp);
    shift_t s;
    int     p;
    p = a_exp + b_exp;
    if (c_exp >= p) begin
      s.right = 1'b1;
      s.amt   = 8'(c_exp - p);
    end else begin
      s.right = 1'b0;
      s.amt   = 8'(p - c_exp);
    end
    return s;
  endfunction

endpackage

// File: rtl/svreal_mul_sched_if.sv
// Requester and response bundle of the shared multiplier scheduler.
// Handshake: a transfer happens in any cycle where valid && ready; valid never waits on ready.
interface svreal_mul_sched_if #(
  parameter int N_REQ   = 4,
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 17,
  parameter int C_WIDTH = 18,
  parameter int ID_W    = svreal_sched_pkg::clog2_min1(N_REQ)
);
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*A_WIDTH-1:0] req_a;
  logic [N_REQ*B_WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [C_WIDTH-1:0]       rsp_c;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_c
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_c
  );
endinterface

// File: rtl/svreal_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping around.
// ptr moves past the winner only when the grant is actually taken (en).
module svreal_rr_arbiter
  import svreal_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = clog2_min1(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;

  // Scanning indices ptr..2N-1 modulo N visits ptr..N-1 then 0..ptr-1.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    for (int k = 0; k < 2 * N_REQ; k++) begin
      if (!found && (k >= int'(ptr_q)) && req[k % N_REQ]) begin
        found    = 1'b1;
        grant_id = ID_W'(k % N_REQ);
      end
    end
    grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = found && (grant_id == ID_W'(i));
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en && found) begin
      ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/svreal_mul_sched.sv
// Shares one two-stage fixed-point multiplier between N_REQ requesters.
// Stage 1 holds the granted operands; stage 2 holds the rescaled product and drives the response.
module svreal_mul_sched
  import svreal_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int A_WIDTH    = 16,
  parameter int A_EXPONENT = -8,
  parameter int B_WIDTH    = 17,
  parameter int B_EXPONENT = -9,
  parameter int C_WIDTH    = 18,
  parameter int C_EXPONENT = -10
) (
  input logic               clk,
  input logic               rst,
  svreal_mul_sched_if.slave bus
);

  localparam int     ID_W = clog2_min1(N_REQ);
  localparam int     PW   = A_WIDTH + B_WIDTH;
  localparam int     EW   = PW + C_WIDTH;
  localparam shift_t SH   = rescale_shift(A_EXPONENT, B_EXPONENT, C_EXPONENT);

  logic               en;
  logic               hs;
  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    grant_id;
  logic [A_WIDTH-1:0] sel_a;
  logic [B_WIDTH-1:0] sel_b;

  logic               s1_valid_q, s1_valid_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;
  logic [A_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [B_WIDTH-1:0] s1_b_q, s1_b_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [C_WIDTH-1:0] rsp_c_q, rsp_c_d;

  logic signed [PW-1:0] a_ext, b_ext, prod;
  logic signed [EW-1:0] prod_ext, scaled;

  assign en = !rsp_valid_q || bus.rsp_ready;

  svreal_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.req_valid),
    .en       (en),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign bus.req_ready = (en && !rst) ? grant : '0;
  assign hs            = |bus.req_ready;

  always_comb begin
    sel_a = bus.req_a[int'(grant_id) * A_WIDTH +: A_WIDTH];
    sel_b = bus.req_b[int'(grant_id) * B_WIDTH +: B_WIDTH];
  end

  // Sign-extend before multiplying so the full-width product is exact, then
  // widen again so a left shift keeps the bits that land in the C window.
  always_comb begin
    a_ext    = {{B_WIDTH{s1_a_q[A_WIDTH-1]}}, s1_a_q};
    b_ext    = {{A_WIDTH{s1_b_q[B_WIDTH-1]}}, s1_b_q};
    prod     = a_ext * b_ext;
    prod_ext = {{C_WIDTH{prod[PW-1]}}, prod};
    scaled   = SH.right ? (prod_ext >>> SH.amt) : (prod_ext << SH.amt);
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_id_d     = s1_id_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_c_d     = rsp_c_q;
    if (en) begin
      s1_valid_d  = hs;
      s1_id_d     = grant_id;
      s1_a_d      = sel_a;
      s1_b_d      = sel_b;
      rsp_valid_d = s1_valid_q;
      rsp_id_d    = s1_id_q;
      rsp_c_d     = scaled[C_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_c_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_c_q     <= rsp_c_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_c     = rsp_c_q;

endmodule
